// File: rtl/km_scan_wb.sv
// Keyboard-matrix scanner: row drive, 2-flop column sync, per-key debounce,
// press/release event FIFO and a Wishbone register window with FIFO interrupt.
module km_scan_wb #(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 12,
  parameter int DEBOUNCE       = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int SETTLE_DEFAULT = 240
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [N_ROWS-1:0] km_row,
  input  logic [N_COLS-1:0] km_col,
  input  logic [2:0]        wb_addr,
  output logic [31:0]       wb_rdata,
  input  logic [31:0]       wb_wdata,
  input  logic              wb_we,
  input  logic              wb_cyc,
  output logic              wb_ack,
  output logic              irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] ROW_LAST = 2'(N_ROWS - 1);
  localparam logic [3:0] COL_LAST = 4'(N_COLS - 1);
  localparam logic [2:0] DB_LAST  = 3'(DEBOUNCE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, EMIT} state_t;

  state_t            state;
  logic [1:0]        row;
  logic [3:0]        col;
  logic [15:0]       settle_cnt;
  logic [N_COLS-1:0] col_s1, col_s2, snap;
  logic [N_COLS-1:0] st  [N_ROWS];
  logic [2:0]        cnt [N_ROWS][N_COLS];

  logic              en, ovf;
  logic [15:0]       settle;
  logic [6:0]        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       level;
  logic [31:0]       rd_mux;

  logic       acc, pop, push, push_ok, empty, full;
  logic       key_snap, key_st;
  logic [2:0] key_cnt;
  logic [1:0] next_row;
  logic [6:0] head;
  logic       unused_wdata;

  assign acc      = wb_cyc & ~wb_ack;
  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(FIFO_DEPTH));
  assign pop      = acc & ~wb_we & (wb_addr == 3'd1) & ~empty;
  assign key_snap = snap[col];
  assign key_st   = st[row][col];
  assign key_cnt  = cnt[row][col];
  assign push     = (state == EMIT) && (key_snap != key_st) && (key_cnt == DB_LAST);
  assign push_ok  = push & (~full | pop);
  assign next_row = (row == ROW_LAST) ? 2'd0 : row + 2'd1;
  assign head     = fifo_mem[rd_ptr];
  assign unused_wdata = ^wb_wdata[31:16];

  // Scan sequencer; the row index survives IDLE so a re-enable resumes where it stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      settle_cnt <= '0;
      km_row     <= '1;
      col_s1     <= '1;
      col_s2     <= '1;
      snap       <= '0;
      for (int r = 0; r < N_ROWS; r++) begin
        st[r] <= '0;
        for (int c = 0; c < N_COLS; c++) cnt[r][c] <= '0;
      end
    end else begin
      col_s1 <= km_col;
      col_s2 <= col_s1;
      case (state)
        IDLE: begin
          if (en) begin
            state      <= DRIVE;
            km_row     <= ~(N_ROWS'(1) << row);
            settle_cnt <= 16'd1;
          end
        end
        DRIVE: begin
          if (settle_cnt >= settle) state <= SAMPLE;
          else settle_cnt <= settle_cnt + 16'd1;
        end
        SAMPLE: begin
          snap   <= ~col_s2;
          col    <= '0;
          km_row <= '1;
          state  <= EMIT;
        end
        EMIT: begin
          if (key_snap == key_st) begin
            cnt[row][col] <= '0;
          end else if (key_cnt == DB_LAST) begin
            st[row][col]  <= key_snap;
            cnt[row][col] <= '0;
          end else begin
            cnt[row][col] <= key_cnt + 3'd1;
          end
          if (col == COL_LAST) begin
            row <= next_row;
            if (en) begin
              state      <= DRIVE;
              km_row     <= ~(N_ROWS'(1) << next_row);
              settle_cnt <= 16'd1;
            end else begin
              state <= IDLE;
            end
          end else begin
            col <= col + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {key_snap, row, col};
  end

  // A pop and a push in the same cycle leave the level unchanged, even when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      irq    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      irq <= ~empty;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (wb_addr)
      3'd0: rd_mux = {20'b0, 4'(level), 5'b0, ovf, empty, en};
      3'd1: if (!empty) rd_mux = {1'b1, 22'b0, head[6], 2'b0, head[5:4], head[3:0]};
      3'd2: rd_mux = {16'b0, settle};
      3'd4, 3'd5, 3'd6, 3'd7:
        if (int'(wb_addr[1:0]) < N_ROWS) rd_mux = 32'(st[wb_addr[1:0]]);
      default: rd_mux = '0;
    endcase
  end

  // Register side effects land on the edge that raises wb_ack; a dropped push beats a same-cycle OVF clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
      en       <= 1'b0;
      ovf      <= 1'b0;
      settle   <= 16'(SETTLE_DEFAULT);
    end else begin
      wb_ack   <= acc;
      wb_rdata <= (acc & ~wb_we) ? rd_mux : 32'd0;
      if (acc & wb_we) begin
        case (wb_addr)
          3'd0: begin
            en <= wb_wdata[0];
            if (wb_wdata[2]) ovf <= 1'b0;
          end
          3'd2:    settle <= wb_wdata[15:0];
          default: ;
        endcase
      end
      if (push & full & ~pop) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_km_scan_wb.sv
// Self-checking bench for km_scan_wb: directed scenarios plus random key activity,
// checked against a scan-level key/FIFO model.
module tb_km_scan_wb;
  localparam int NR = 4, NC = 12, DB = 4, FD = 8;
  localparam int ROW_PERIOD = 4 + 1 + NC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NR-1:0] km_row;
  logic [NC-1:0] km_col;
  logic [2:0]    wb_addr = '0;
  logic [31:0]   wb_rdata;
  logic [31:0]   wb_wdata = '0;
  logic          wb_we = 1'b0, wb_cyc = 1'b0, wb_ack, irq;

  logic [NC-1:0] pressed [NR];
  logic [NC-1:0] m_st [NR];
  int            m_cnt [NR][NC];
  logic [31:0]   exp_q [$];
  bit            m_ovf, m_en, row_done_flag;
  int            scans_of [NR];
  int            prev_low, last_row;
  int            n_checks = 0, n_err = 0;
  logic [31:0]   rd;

  km_scan_wb #(.N_ROWS(NR), .N_COLS(NC), .DEBOUNCE(DB), .FIFO_DEPTH(FD), .SETTLE_DEFAULT(240)) dut (
    .clk(clk), .rst_n(rst_n), .km_row(km_row), .km_col(km_col),
    .wb_addr(wb_addr), .wb_rdata(wb_rdata), .wb_wdata(wb_wdata), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_ack(wb_ack), .irq(irq)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    km_col = '1;
    for (int r = 0; r < NR; r++)
      if (!km_row[r]) km_col = km_col & ~pressed[r];
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_st[r] = '0;
      scans_of[r] = 0;
      for (int c = 0; c < NC; c++) m_cnt[r][c] = 0;
    end
    exp_q.delete();
    m_ovf = 0; m_en = 0; prev_low = -1; last_row = -1;
  endtask

  // One completed scan of row r: each key needs DB consecutive disagreeing scans to flip.
  task automatic model_row(input int r);
    for (int c = 0; c < NC; c++) begin
      bit p = pressed[r][c];
      if (p == m_st[r][c]) m_cnt[r][c] = 0;
      else if (m_cnt[r][c] == DB - 1) begin
        m_st[r][c] = p;
        m_cnt[r][c] = 0;
        if (exp_q.size() < FD)
          exp_q.push_back(32'h8000_0000 | (32'(p) << 8) | (32'(r) << 4) | 32'(c));
        else m_ovf = 1;
      end else m_cnt[r][c]++;
    end
  endtask

  // Every bench cycle goes through here so row completions are never missed.
  task automatic tick();
    int cur;
    @(posedge clk);
    #1;
    cur = -1;
    for (int r = 0; r < NR; r++) if (km_row == ~(NR'(1) << r)) cur = r;
    if (prev_low >= 0 && km_row == '1) begin
      model_row(prev_low);
      scans_of[prev_low]++;
      last_row = prev_low;
      row_done_flag = 1;
    end
    prev_low = cur;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [31:0] csr_exp();
    return {20'b0, 4'(exp_q.size()), 5'b0, m_ovf, (exp_q.size() == 0), m_en};
  endfunction

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
    bit got = 0;
    d = '0;
    wb_addr = a; wb_we = 1'b0; wb_cyc = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (wb_ack) begin got = 1; d = wb_rdata; end
    end
    wb_cyc = 1'b0;
    check_output("read_ack", 32'(got), 32'd1);
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    bit got = 0;
    wb_addr = a; wb_wdata = d; wb_we = 1'b1; wb_cyc = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if (wb_ack) got = 1;
    end
    wb_cyc = 1'b0; wb_we = 1'b0;
    check_output("write_ack", 32'(got), 32'd1);
    if (a == 3'd0) begin
      m_en = d[0];
      if (d[2]) m_ovf = 0;
    end
  endtask

  task automatic rd_check(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    wb_read(a, d);
    check_output(tag, d, exp);
  endtask

  task automatic evt_check(input string tag);
    logic [31:0] exp;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'd0;
    rd_check(3'd1, exp, tag);
  endtask

  task automatic drain_and_check(input string tag);
    rd_check(3'd0, csr_exp(), {tag, "_csr"});
    while (exp_q.size() != 0) evt_check({tag, "_evt"});
    evt_check({tag, "_evt_empty"});
  endtask

  task automatic apply_stimulus(input int r, input logic [NC-1:0] mask);
    pressed[r] = mask;
  endtask

  task automatic wait_row_done();
    row_done_flag = 0;
    for (int i = 0; i < 4 * ROW_PERIOD && !row_done_flag; i++) tick();
    check_output("row_done_wait", 32'(row_done_flag), 32'd1);
  endtask

  task automatic wait_scans(input int r, input int k);
    int target = scans_of[r] + k;
    bit done = 0;
    for (int i = 0; i < (k + 2) * NR * ROW_PERIOD && !done; i++) begin
      tick();
      if (scans_of[r] >= target) done = 1;
    end
    check_output("scan_wait", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    wb_cyc = 1'b0; wb_we = 1'b0;
    for (int r = 0; r < NR; r++) pressed[r] = '0;
    rst_n = 1'b0;
    model_reset();
    ticks(3);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int r = 0; r < NR; r++) pressed[r] = '0;
    model_reset();

    // Reset state
    rst_n = 1'b0;
    ticks(2);
    check_output("rst_km_row", 32'(km_row), 32'hF);
    check_output("rst_ack", 32'(wb_ack), 32'd0);
    check_output("rst_rdata", wb_rdata, 32'd0);
    check_output("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    tick();
    rd_check(3'd0, csr_exp(), "rst_csr");
    rd_check(3'd2, 32'd240, "rst_settle");
    for (int r = 0; r < NR; r++) rd_check(3'(4 + r), 32'(m_st[r]), "rst_state");
    rd_check(3'd3, 32'd0, "unmapped_rd");
    tick();
    check_output("idle_ack_low", 32'(wb_ack), 32'd0);
    check_output("idle_rdata_zero", wb_rdata, 32'd0);

    // Single key (2,5): event on the 4th scan, then its release
    wb_write(3'd2, 32'd4);
    rd_check(3'd2, 32'd4, "settle_rw");
    apply_stimulus(2, 12'h020);
    wb_write(3'd0, 32'd1);
    wait_scans(2, 3);
    ticks(NC + 2);
    check_output("irq_before_4th", 32'(irq), 32'(exp_q.size() != 0));
    wait_scans(2, 1);
    ticks(NC + 2);
    check_output("irq_after_4th", 32'(irq), 32'(exp_q.size() != 0));
    rd_check(3'd6, 32'(m_st[2]), "state2_pressed");
    evt_check("evt_press");
    evt_check("evt_empty");
    ticks(2);
    check_output("irq_after_pop", 32'(irq), 32'(exp_q.size() != 0));
    wait_row_done();
    apply_stimulus(2, 12'h000);
    wait_scans(2, DB);
    ticks(NC + 2);
    evt_check("evt_release");

    // Glitch on (1,3) shorter than the debounce window
    wait_row_done();
    apply_stimulus(1, 12'h008);
    wait_scans(1, DB - 1);
    apply_stimulus(1, 12'h000);
    wait_scans(1, DB + 1);
    ticks(NC + 2);
    check_output("glitch_irq", 32'(irq), 32'(exp_q.size() != 0));
    rd_check(3'd5, 32'(m_st[1]), "glitch_state1");
    evt_check("glitch_evt");

    // Whole row 0 pressed: FIFO fills, later events dropped, OVF set
    wait_row_done();
    apply_stimulus(0, 12'hFFF);
    wait_scans(0, DB);
    ticks(NC + 2);
    rd_check(3'd0, csr_exp(), "ovf_csr");
    rd_check(3'd4, 32'(m_st[0]), "ovf_state0");
    wb_write(3'd0, 32'h5);
    rd_check(3'd0, csr_exp(), "ovf_cleared_csr");
    drain_and_check("ovf_drain");
    wait_row_done();
    apply_stimulus(0, 12'h000);
    wait_scans(0, DB);
    ticks(NC + 2);
    drain_and_check("release_drain");
    wb_write(3'd0, 32'h5);

    // EN cleared while row 1 is driven: row 1 finishes, then the scan parks
    begin
      bit seen = 0;
      int bad = 0;
      for (int i = 0; i < 2 * NR * ROW_PERIOD && !seen; i++) begin
        tick();
        if (km_row == 4'b1101) seen = 1;
      end
      check_output("row1_drive_seen", 32'(seen), 32'd1);
      wb_write(3'd0, 32'd0);
      wait_scans(1, 1);
      check_output("last_row_is_1", 32'(last_row), 32'd1);
      for (int i = 0; i < 3 * ROW_PERIOD; i++) begin
        tick();
        if (km_row != 4'hF) bad++;
      end
      check_output("parked_rows_idle", 32'(bad), 32'd0);
      wb_write(3'd0, 32'd1);
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
        tick();
        if (km_row != 4'hF) seen = 1;
      end
      check_output("resume_row2", 32'(km_row), 32'(4'b1011));
    end

    // Random key activity, checked after the scan is parked
    for (int i = 0; i < 60; i++) begin
      wait_row_done();
      if ($urandom_range(0, 1) == 0) begin
        int r = $urandom_range(0, NR - 1);
        int c = $urandom_range(0, NC - 1);
        pressed[r][c] = ~pressed[r][c];
      end
    end
    wb_write(3'd0, 32'd0);
    ticks(3 * ROW_PERIOD);
    for (int r = 0; r < NR; r++) rd_check(3'(4 + r), 32'(m_st[r]), "rand_state");
    drain_and_check("rand_drain");
    wb_write(3'd0, 32'h4);
    rd_check(3'd0, csr_exp(), "rand_ovf_clear");

    // Reset asserted mid-EMIT with three events queued
    do_reset();
    wb_write(3'd2, 32'd4);
    apply_stimulus(3, 12'h007);
    wb_write(3'd0, 32'd1);
    wait_scans(3, DB);
    ticks(5);
    check_output("pre_rst_irq", 32'(irq), 32'(exp_q.size() != 0));
    rd_check(3'd0, csr_exp(), "pre_rst_csr");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_output("async_rst_km_row", 32'(km_row), 32'hF);
    check_output("async_rst_irq", 32'(irq), 32'd0);
    ticks(3);
    rst_n = 1'b1;
    tick();
    rd_check(3'd0, csr_exp(), "post_rst_csr");
    for (int r = 0; r < NR; r++) rd_check(3'(4 + r), 32'(m_st[r]), "post_rst_state");
    ticks(2 * ROW_PERIOD);
    check_output("post_rst_km_row", 32'(km_row), 32'hF);
    check_output("post_rst_irq", 32'(irq), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
